// File: rtl/atm_dos_ctrl_pkg.sv
// Shared definitions for the ATM DOS-state controller: NMI FSM encodings and stall defaults.
package atm_dos_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_REQ = 2'd1,
        S_NMI = 2'd2
    } nmi_state_e;

    localparam int STALL_CYC_DEF = 3;
    localparam int CNT_W         = 3;

endpackage

// File: rtl/atm_dos_ctrl_zclk_stall_cnt.sv
// Z80 clock stall sequencer: stall starts combinationally with the DOS-on strobe,
// then a down-counter holds it for STALL_CYC more fclk cycles.
module zclk_stall_cnt
    import atm_dos_ctrl_pkg::*;
#(
    parameter int STALL_CYC = STALL_CYC_DEF
) (
    input  logic fclk,
    input  logic rst,
    input  logic on_req,
    output logic zclk_stall
);

    logic [CNT_W-1:0] cnt;

    // Reload on every strobe so back-to-back entries retrigger the full stall.
    always_ff @(posedge fclk) begin
        if (rst)
            cnt <= '0;
        else if (on_req)
            cnt <= CNT_W'(STALL_CYC);
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign zclk_stall = on_req | (cnt != '0);

endmodule

// File: rtl/atm_dos_ctrl.sv
// Central DOS flag for the four ATM pager windows, with Z80 stall on DOS entry
// and NMI entry/RETN exit sequencing that saves and restores DOS.
module atm_dos_ctrl
    import atm_dos_ctrl_pkg::*;
#(
    parameter int STALL_CYC = STALL_CYC_DEF,
    parameter bit DOS_RST   = 1'b1
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       zneg,
    input  logic [3:0] dos_on_req,
    input  logic [3:0] dos_off_req,
    input  logic       dos_force_wr,
    input  logic       dos_force_val,
    input  logic       nmi_req,
    input  logic       retn_stb,
    output logic       dos,
    output logic       in_nmi,
    output logic       zclk_stall,
    output logic       nmi_n
);

    nmi_state_e state, state_nx;
    logic       nmi_prev;
    logic       nmi_rise;
    logic       nmi_enter;
    logic       nmi_exit;
    logic       saved_dos;
    logic       any_on;
    logic       any_off;

    assign any_on   = |dos_on_req;
    assign any_off  = |dos_off_req;
    assign nmi_rise = nmi_req & ~nmi_prev;

    // Unreset on purpose: a level held high through reset must not look like a new edge.
    always_ff @(posedge fclk)
        nmi_prev <= nmi_req;

    always_ff @(posedge fclk) begin
        if (rst)
            state <= S_RUN;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        nmi_enter = 1'b0;
        nmi_exit  = 1'b0;
        unique case (state)
            S_RUN: if (nmi_rise) state_nx = S_REQ;
            S_REQ: if (zneg) begin
                state_nx  = S_NMI;
                nmi_enter = 1'b1;
            end
            S_NMI: if (retn_stb) begin
                state_nx = S_RUN;
                nmi_exit = 1'b1;
            end
            default: state_nx = S_RUN;
        endcase
    end

    assign nmi_n = (state != S_REQ);

    always_ff @(posedge fclk) begin
        if (rst) begin
            dos       <= DOS_RST;
            in_nmi    <= 1'b0;
            saved_dos <= 1'b0;
        end else begin
            if (nmi_enter) begin
                saved_dos <= dos;
                in_nmi    <= 1'b1;
            end else if (nmi_exit) begin
                in_nmi    <= 1'b0;
            end

            if (nmi_enter)         dos <= 1'b1;
            else if (nmi_exit)     dos <= saved_dos;
            else if (dos_force_wr) dos <= dos_force_val;
            else if (any_on)       dos <= 1'b1;
            else if (any_off)      dos <= 1'b0;
        end
    end

    zclk_stall_cnt #(
        .STALL_CYC (STALL_CYC)
    ) u_stall (
        .fclk       (fclk),
        .rst        (rst),
        .on_req     (any_on),
        .zclk_stall (zclk_stall)
    );

endmodule

// File: doc/atm_dos_ctrl.md
Name: atm_dos_ctrl

Overview:
Central DOS-state controller for the four ATM pager windows (0000/4000/8000/C000).
- Merges per-window dos_turn_on/dos_turn_off strobes into a single registered DOS flag.
- Sequences the Z80 clock stall after DOS entry.
- Tracks NMI entry and RETN exit, and saves/restores DOS across the NMI.
- Its dos and in_nmi outputs feed back to every pager window and to ROM mapping.

Parameters:
STALL_CYC, 3, number of fclk cycles zclk_stall is held after the DOS-on cycle (1..7).
DOS_RST, 1, value of dos after reset (machine boots into DOS ROM).

Ports:
fclk  in  1  system clock (28 MHz).
rst  in  1  synchronous reset, active-high.
zneg  in  1  Z80 clock negative-edge strobe, one fclk wide.
dos_on_req  in  4  per-window DOS turn-on strobes, bit n = window n, one fclk wide.
dos_off_req  in  4  per-window DOS turn-off strobes (RAM opcode fetch), one fclk wide.
dos_force_wr  in  1  port write strobe that loads dos from dos_force_val.
dos_force_val  in  1  value for forced DOS write.
nmi_req  in  1  NMI button / NMI entry level, asynchronous to Z80 timing.
retn_stb  in  1  RETN executed, one fclk wide.
dos  out  1  current DOS state.
in_nmi  out  1  NMI service active; window 0 maps the last RAM page.
zclk_stall  out  1  stall Z80 clock.
nmi_n  out  1  NMI to Z80, active-low.

Behaviour:
Reset values:
- dos = DOS_RST
- in_nmi = 0
- nmi_n = 1
- stall counter = 0
- saved_dos = 0
- FSM = S_RUN

DOS flag:
- Updated on the fclk edge following the request; 1-cycle latency.
- Priority, highest first: rst > NMI entry > RETN exit > dos_force_wr > any dos_on_req > any dos_off_req > hold.
- dos_on_req and dos_off_req asserted in the same cycle (any bits): on wins, dos <= 1.
- Multiple on bits together are treated as one request.

Stall:
- zclk_stall = (|dos_on_req) | (cnt != 0). It is combinational so the stall starts in the same cycle as the strobe.
- On any dos_on_req, cnt <= STALL_CYC. Otherwise, if cnt != 0, cnt <= cnt - 1.
- A new on_req while cnt != 0 reloads the counter (retrigger).
- With STALL_CYC = 3 the total stall is 4 fclk cycles.
- cnt width is 3 bits; no wrap, it saturates at 0.
- dos_force_wr does not stall.

NMI FSM, states S_RUN, S_REQ, S_NMI:
- S_RUN: on a rising edge of nmi_req (registered previous-value compare) go to S_REQ and drive nmi_n = 0.
- S_REQ: hold nmi_n = 0 until zneg. On the zneg cycle:
  - saved_dos <= dos
  - dos <= 1
  - in_nmi <= 1
  - nmi_n <= 1
  - go to S_NMI
- S_NMI: retn_stb gives dos <= saved_dos, in_nmi <= 0, go to S_RUN.
- S_NMI: further nmi_req edges are ignored (no nesting).
- S_NMI: dos_on/off/force requests are still applied to dos but do not change saved_dos.
- retn_stb in S_RUN or S_REQ: ignored.
- NMI entry cycle coinciding with dos_on_req: dos = 1, and the stall still loads.
- rst in any state: all registers return to reset values in the next cycle. A pending NMI is dropped.

Decomposition:
- Shared package/include: NMI FSM state encodings (S_RUN=2'd0, S_REQ=2'd1, S_NMI=2'd2) and the default STALL_CYC constant. Reuse the existing tune.v include for global defines.
- One natural sub-module, zclk_stall_cnt: counter plus combinational stall output, parameterised by STALL_CYC. Everything else stays flat.

Test Plan:
- Reset: assert rst 2 cycles -> dos=1, in_nmi=0, nmi_n=1, zclk_stall=0. Then dos_off_req=4'b0001 for 1 cycle -> dos=0 next cycle.
- DOS-on stall: dos=0, dos_on_req=4'b0001 at cycle T -> zclk_stall=1 for cycles T..T+3 and 0 at T+4; dos=1 from T+1.
- Collision and retrigger: dos_on_req=4'b0010 with dos_off_req=4'b1000 in the same cycle -> dos=1. A second on_req at T+2 -> stall extends to T+5.
- NMI entry/exit: dos=0, raise nmi_req -> nmi_n=0 until the next zneg; on that cycle in_nmi=1 and dos=1. dos_off_req then gives dos=0. retn_stb -> dos=0 (saved), in_nmi=0, FSM back to S_RUN.
- NMI saving DOS=1: dos=1, NMI, dos_off_req during NMI, retn_stb -> dos=1 restored. A second nmi_req edge during S_NMI leaves nmi_n=1.
- Reset mid-NMI: rst while in S_REQ with nmi_n=0 -> nmi_n=1, in_nmi=0, dos=1 next cycle. retn_stb afterwards has no effect.
